mac_result_packer: RTL

MAC_RESULT_PACKER -- requirements
Module: mac_result_packer

---
 rtl/mac_result_packer_pkg.sv | 26 ++
 rtl/mac_out_fifo.sv | 60 ++++++
 rtl/mac_result_packer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mac_result_packer_pkg.sv
// Shared MAC definitions: lane geometry per mode and the layout of one
// packed output word as it is stored in the output FIFO.
package mac_result_packer_pkg;

  localparam int INT8_W     = 8;
  localparam int FP16_W     = 16;
  localparam int WORD_W     = 32;
  localparam int INT8_LANES = 4;
  localparam int FP16_LANES = 2;
  localparam int LANES_W    = 3;

  // One FIFO entry: packed lanes, lane format and number of filled lanes.
  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic               fp;
    logic [LANES_W-1:0] lanes;
  } word_entry_t;

  localparam int ENTRY_W = $bits(word_entry_t);

  // Number of lanes that completes a word in the given mode.
  function automatic logic [LANES_W-1:0] lanes_per_word(input logic fp);
    return fp ? LANES_W'(FP16_LANES) : LANES_W'(INT8_LANES);
  endfunction

endpackage

// File: rtl/mac_out_fifo.sv
// First-word-fall-through FIFO for packed result words. A write into a
// full FIFO is refused unless a read happens in the same cycle; the refusal
// is reported on drop so the owner can flag the lost word.
module mac_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; validity comes only from count,
  // and leaving the array out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_result_packer.sv
// Collects MAC results into 32-bit words: four int8 lanes or two fp16
// lanes per word. Issues are delayed by LAT cycles to line up with the MAC
// result buses, packed in arrival order and queued in an output FIFO.
module mac_result_packer
  import mac_result_packer_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_fp,
  input  logic [INT8_W-1:0]   result_int8,
  input  logic [FP16_W-1:0]   result_fp16,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_fp,
  output logic [LANES_W-1:0]  out_lanes,
  output logic                ovf
);

  logic [LAT-1:0]     dly_valid;
  logic [LAT-1:0]     dly_fp;
  logic               cap_valid;
  logic               cap_fp;

  logic [WORD_W-1:0]  part_data;
  logic               part_fp;
  logic [LANES_W-1:0] part_lanes;
  logic               flush_pend;

  logic [WORD_W-1:0]  nxt_data;
  logic               nxt_fp;
  logic [LANES_W-1:0] nxt_lanes;
  logic               nxt_pend;
  logic [WORD_W-1:0]  fill_data;
  logic [LANES_W-1:0] fill_lanes;
  logic               close_req;
  logic               push;
  word_entry_t        push_word;

  word_entry_t        head_word;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_drop;

  assign cap_valid = dly_valid[LAT-1];
  assign cap_fp    = dly_fp[LAT-1];

  // Issue delay line: the last stage marks the cycle the MAC result is valid.
  // NOTE: non-blocking assignments make every stage take its neighbour's old
  // value, so the loop order cannot collapse the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_valid <= '0;
      dly_fp    <= '0;
    end else begin
      dly_valid[0] <= issue_valid;
      dly_fp[0]    <= issue_fp;
      for (int i = 1; i < LAT; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_fp[i]    <= dly_fp[i-1];
      end
    end
  end

  // Packer next state: place the captured lane, decide whether a word closes.
  // A mode change closes the old word and parks the new element; a flush
  // arriving in that same cycle is carried one cycle so it closes the new
  // element next, keeping pushes to one per cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned and no latch is inferred.
    nxt_data   = part_data;
    nxt_fp     = part_fp;
    nxt_lanes  = part_lanes;
    nxt_pend   = 1'b0;
    fill_data  = part_data;
    fill_lanes = part_lanes + LANES_W'(1);
    close_req  = flush | flush_pend;
    push       = 1'b0;
    push_word  = '{data: part_data, fp: part_fp, lanes: part_lanes};

    if (cap_valid) begin
      if ((part_lanes != '0) && (cap_fp != part_fp)) begin
        push      = 1'b1;
        nxt_data  = cap_fp ? WORD_W'(result_fp16) : WORD_W'(result_int8);
        nxt_fp    = cap_fp;
        nxt_lanes = LANES_W'(1);
        nxt_pend  = close_req;
      end else begin
        if (cap_fp) fill_data[{part_lanes[0], 4'b0000} +: FP16_W] = result_fp16;
        else        fill_data[{part_lanes[1:0], 3'b000} +: INT8_W] = result_int8;
        if ((fill_lanes == lanes_per_word(cap_fp)) || close_req) begin
          push      = 1'b1;
          push_word = '{data: fill_data, fp: cap_fp, lanes: fill_lanes};
          nxt_data  = '0;
          nxt_fp    = 1'b0;
          nxt_lanes = '0;
        end else begin
          nxt_data  = fill_data;
          nxt_fp    = cap_fp;
          nxt_lanes = fill_lanes;
        end
      end
    end else if (close_req && (part_lanes != '0)) begin
      push      = 1'b1;
      nxt_data  = '0;
      nxt_fp    = 1'b0;
      nxt_lanes = '0;
    end
  end

  // Partial word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_data  <= '0;
      part_fp    <= 1'b0;
      part_lanes <= '0;
      flush_pend <= 1'b0;
    end else begin
      part_data  <= nxt_data;
      part_fp    <= nxt_fp;
      part_lanes <= nxt_lanes;
      flush_pend <= nxt_pend;
    end
  end

  mac_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready),
    .head      (head_word),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  // Sticky overflow: any refused word latches it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (fifo_drop) ovf <= 1'b1;
  end

  // The head is masked while empty so reset and idle show an all-zero word.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head_word.data  : '0;
  assign out_fp    = out_valid ? head_word.fp    : 1'b0;
  assign out_lanes = out_valid ? head_word.lanes : '0;

endmodule
